// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: SPM/bus access FSM feeding the IF/ID pipeline register.
// Define IF_SPM_FETCH_EN to decode addr[29:27]==SPM_IDX to the scratch-pad; otherwise every fetch uses the bus.
module if_fetch_stage #(
  parameter int          WORD     = 32,
  parameter int          ADDR_W   = 30,
  parameter logic [2:0]  SPM_IDX  = 3'b001,
  parameter logic [29:0] RESET_PC = 30'h0,
  parameter logic [31:0] NOP      = 32'h0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic [ADDR_W-1:0] new_pc_i,
  input  logic              br_taken_i,
  input  logic [ADDR_W-1:0] br_addr_i,
  output logic              busy_o,
  input  logic [WORD-1:0]   spm_rd_data_i,
  output logic [ADDR_W-1:0] spm_addr_o,
  output logic              spm_as_o,
  output logic              spm_rw_o,
  output logic [WORD-1:0]   spm_wr_data_o,
  input  logic [WORD-1:0]   bus_rd_data_i,
  input  logic              bus_rdy_i,
  input  logic              bus_grnt_i,
  output logic              bus_req_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic              bus_as_o,
  output logic              bus_rw_o,
  output logic [WORD-1:0]   bus_wr_data_o,
  output logic [ADDR_W-1:0] if_pc_o,
  output logic [WORD-1:0]   if_inst_o,
  output logic              if_en_o
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    ACCESS,
    STALL
  } state_e;

  state_e              state_q, state_d;
  logic                bus_req_q, bus_req_d;
  logic                bus_as_q, bus_as_d;
  logic                bus_rw_q, bus_rw_d;
  logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
  logic [WORD-1:0]     rd_buf_q, rd_buf_d;
  logic [ADDR_W-1:0]   if_pc_q, if_pc_d;
  logic [WORD-1:0]     if_inst_q, if_inst_d;
  logic                if_en_q, if_en_d;

  logic [WORD-1:0]     insn;
  logic                busy;
  logic                spm_as;
  logic                spm_hit;
  logic                hold;

`ifdef IF_SPM_FETCH_EN
  assign spm_hit = (if_pc_q[ADDR_W-1 -: 3] == SPM_IDX);
`else
  logic [2:0] spm_idx_unused;
  assign spm_idx_unused = SPM_IDX;
  assign spm_hit        = 1'b0;
`endif

  // Access FSM: SPM answers in the IDLE cycle, the bus takes IDLE->REQ->ACCESS.
  always_comb begin
    state_d    = state_q;
    bus_req_d  = bus_req_q;
    bus_as_d   = bus_as_q;
    bus_rw_d   = bus_rw_q;
    bus_addr_d = bus_addr_q;
    rd_buf_d   = rd_buf_q;
    insn       = '0;
    busy       = 1'b0;
    spm_as     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!flush_i) begin
          if (spm_hit) begin
            if (!stall_i) begin
              spm_as = 1'b1;
              insn   = spm_rd_data_i;
            end
          end else begin
            busy       = 1'b1;
            state_d    = REQ;
            bus_req_d  = 1'b1;
            bus_addr_d = if_pc_q;
            bus_rw_d   = 1'b0;
          end
        end
      end
      REQ: begin
        busy = 1'b1;
        if (bus_grnt_i) begin
          state_d  = ACCESS;
          bus_as_d = 1'b1;
        end
      end
      ACCESS: begin
        bus_as_d = 1'b0;
        if (bus_rdy_i) begin
          insn       = bus_rd_data_i;
          rd_buf_d   = bus_rd_data_i;
          bus_req_d  = 1'b0;
          bus_addr_d = '0;
          bus_rw_d   = 1'b0;
          state_d    = stall_i ? STALL : IDLE;
        end else begin
          busy = 1'b1;
        end
      end
      STALL: begin
        insn = rd_buf_q;
        if (!stall_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A held stage ignores flush/branch entirely, so X on those inputs cannot leak in.
  assign hold = stall_i | busy;

  always_comb begin
    if_pc_d   = if_pc_q;
    if_inst_d = if_inst_q;
    if_en_d   = if_en_q;
    if (!hold) begin
      if (flush_i) begin
        if_pc_d   = new_pc_i;
        if_inst_d = NOP[WORD-1:0];
        if_en_d   = 1'b0;
      end else if (br_taken_i) begin
        if_pc_d   = br_addr_i;
        if_inst_d = insn;
        if_en_d   = 1'b1;
      end else begin
        if_pc_d   = if_pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
        if_inst_d = insn;
        if_en_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      bus_req_q  <= 1'b0;
      bus_as_q   <= 1'b0;
      bus_rw_q   <= 1'b0;
      bus_addr_q <= '0;
      rd_buf_q   <= '0;
      if_pc_q    <= RESET_PC[ADDR_W-1:0];
      if_inst_q  <= NOP[WORD-1:0];
      if_en_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      bus_req_q  <= bus_req_d;
      bus_as_q   <= bus_as_d;
      bus_rw_q   <= bus_rw_d;
      bus_addr_q <= bus_addr_d;
      rd_buf_q   <= rd_buf_d;
      if_pc_q    <= if_pc_d;
      if_inst_q  <= if_inst_d;
      if_en_q    <= if_en_d;
    end
  end

  assign busy_o        = busy;
  assign spm_addr_o    = if_pc_q;
  assign spm_as_o      = spm_as;
  assign spm_rw_o      = 1'b0;
  assign spm_wr_data_o = '0;
  assign bus_req_o     = bus_req_q;
  assign bus_addr_o    = bus_addr_q;
  assign bus_as_o      = bus_as_q;
  assign bus_rw_o      = bus_rw_q;
  assign bus_wr_data_o = '0;
  assign if_pc_o       = if_pc_q;
  assign if_inst_o     = if_inst_q;
  assign if_en_o       = if_en_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: bus fetch cadence, stall/flush/branch, wrap, reset and SPM path.
module tb_if_fetch_stage;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        flush;
  logic [29:0] new_pc;
  logic        br_taken;
  logic [29:0] br_addr;
  logic        busy;
  logic [31:0] spm_rd_data;
  logic [29:0] spm_addr;
  logic        spm_as;
  logic        spm_rw;
  logic [31:0] spm_wr_data;
  logic [31:0] bus_rd_data;
  logic        bus_rdy;
  logic        bus_grnt;
  logic        bus_req;
  logic [29:0] bus_addr;
  logic        bus_as;
  logic        bus_rw;
  logic [31:0] bus_wr_data;
  logic [29:0] if_pc;
  logic [31:0] if_inst;
  logic        if_en;

  int checks;
  int failures;

  if_fetch_stage dut (
    .clk           (clk),
    .rst           (rst),
    .stall_i       (stall),
    .flush_i       (flush),
    .new_pc_i      (new_pc),
    .br_taken_i    (br_taken),
    .br_addr_i     (br_addr),
    .busy_o        (busy),
    .spm_rd_data_i (spm_rd_data),
    .spm_addr_o    (spm_addr),
    .spm_as_o      (spm_as),
    .spm_rw_o      (spm_rw),
    .spm_wr_data_o (spm_wr_data),
    .bus_rd_data_i (bus_rd_data),
    .bus_rdy_i     (bus_rdy),
    .bus_grnt_i    (bus_grnt),
    .bus_req_o     (bus_req),
    .bus_addr_o    (bus_addr),
    .bus_as_o      (bus_as),
    .bus_rw_o      (bus_rw),
    .bus_wr_data_o (bus_wr_data),
    .if_pc_o       (if_pc),
    .if_inst_o     (if_inst),
    .if_en_o       (if_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    rst         = 1'b1;
    stall       = 1'b0;
    flush       = 1'b0;
    new_pc      = '0;
    br_taken    = 1'b0;
    br_addr     = '0;
    spm_rd_data = 32'h0;
    bus_rd_data = 32'h2;
    bus_grnt    = 1'b1;
    bus_rdy     = 1'b1;
    tick(2);
    checkOutput("rst_pc",      32'(if_pc),    32'h0);
    checkOutput("rst_inst",    if_inst,       32'h0);
    checkOutput("rst_en",      32'(if_en),    32'h0);
    checkOutput("rst_req",     32'(bus_req),  32'h0);
    checkOutput("rst_as",      32'(bus_as),   32'h0);
    checkOutput("rst_addr",    32'(bus_addr), 32'h0);
    checkOutput("tie_spm_rw",  32'(spm_rw),   32'h0);
    checkOutput("tie_bus_wd",  bus_wr_data,   32'h0);

    // Bus fetch with immediate grant/ready: three cycles per word.
    rst = 1'b0;
    #1;
    checkOutput("idle_busy", 32'(busy), 32'h1);
    tick(1);
    checkOutput("req_req",   32'(bus_req),  32'h1);
    checkOutput("req_addr",  32'(bus_addr), 32'h0);
    checkOutput("req_en",    32'(if_en),    32'h0);
    tick(1);
    checkOutput("acc_as",    32'(bus_as),   32'h1);
    checkOutput("acc_busy",  32'(busy),     32'h0);
    tick(1);
    checkOutput("f1_pc",     32'(if_pc),    32'h1);
    checkOutput("f1_inst",   if_inst,       32'h2);
    checkOutput("f1_en",     32'(if_en),    32'h1);
    checkOutput("f1_req",    32'(bus_req),  32'h0);
    checkOutput("f1_as",     32'(bus_as),   32'h0);
    tick(1);
    checkOutput("f2_addr",   32'(bus_addr), 32'h1);
    tick(2);
    checkOutput("f2_pc",     32'(if_pc),    32'h2);
    tick(3);
    checkOutput("f3_pc",     32'(if_pc),    32'h3);

    // Stall: in-flight access completes into the buffer, outputs frozen.
    stall       = 1'b1;
    bus_rd_data = 32'h7;
    tick(3);
    checkOutput("stl_pc",    32'(if_pc),    32'h3);
    checkOutput("stl_inst",  if_inst,       32'h2);
    checkOutput("stl_req",   32'(bus_req),  32'h0);
    bus_rd_data = 32'h9;
    tick(2);
    checkOutput("stl_pc2",   32'(if_pc),    32'h3);
    checkOutput("stl_busy",  32'(busy),     32'h0);
    stall = 1'b0;
    tick(1);
    checkOutput("res_pc",    32'(if_pc),    32'h4);
    checkOutput("res_inst",  if_inst,       32'h7);

    // Stall and flush together: hold wins, no new request.
    stall    = 1'b1;
    flush    = 1'b1;
    new_pc   = 30'h1000;
    br_taken = 1'bx;
    br_addr  = 'x;
    tick(2);
    checkOutput("sf_pc",     32'(if_pc),    32'h4);
    checkOutput("sf_inst",   if_inst,       32'h7);
    checkOutput("sf_en",     32'(if_en),    32'h1);
    checkOutput("sf_req",    32'(bus_req),  32'h0);

    stall = 1'b0;
    tick(1);
    checkOutput("fl_pc",     32'(if_pc),    32'h1000);
    checkOutput("fl_inst",   if_inst,       32'h0);
    checkOutput("fl_en",     32'(if_en),    32'h0);
    tick(1);
    checkOutput("fl_pc2",    32'(if_pc),    32'h1000);
    checkOutput("fl_req",    32'(bus_req),  32'h0);

    // Branch redirect, then sequential again.
    flush       = 1'b0;
    br_taken    = 1'b1;
    br_addr     = 30'h1000000;
    bus_rd_data = 32'h2;
    tick(3);
    checkOutput("br_pc",     32'(if_pc),    32'h1000000);
    checkOutput("br_inst",   if_inst,       32'h2);
    checkOutput("br_en",     32'(if_en),    32'h1);
    br_taken = 1'b0;
    tick(3);
    checkOutput("br_seq",    32'(if_pc),    32'h1000001);

    // PC wrap at the top of the word-address space.
    flush  = 1'b1;
    new_pc = 30'h3FFFFFFF;
    tick(1);
    checkOutput("wr_load",   32'(if_pc),    32'h3FFFFFFF);
    flush = 1'b0;
    tick(3);
    checkOutput("wr_pc",     32'(if_pc),    32'h0);
    checkOutput("wr_en",     32'(if_en),    32'h1);

    // Flush arriving mid-transaction does not abort it.
    tick(1);
    flush  = 1'b1;
    new_pc = 30'h2000;
    tick(1);
    checkOutput("fm_as",     32'(bus_as),   32'h1);
    tick(1);
    checkOutput("fm_pc",     32'(if_pc),    32'h2000);
    checkOutput("fm_en",     32'(if_en),    32'h0);
    checkOutput("fm_req",    32'(bus_req),  32'h0);
    flush = 1'b0;

    // Delayed grant and ready.
    bus_grnt = 1'b0;
    bus_rdy  = 1'b0;
    tick(3);
    checkOutput("wg_req",    32'(bus_req),  32'h1);
    checkOutput("wg_as",     32'(bus_as),   32'h0);
    checkOutput("wg_busy",   32'(busy),     32'h1);
    checkOutput("wg_addr",   32'(bus_addr), 32'h2000);
    bus_grnt = 1'b1;
    tick(1);
    checkOutput("wr_as",     32'(bus_as),   32'h1);
    checkOutput("wr_busy",   32'(busy),     32'h1);
    tick(1);
    checkOutput("wr_as0",    32'(bus_as),   32'h0);
    checkOutput("wr_pchold", 32'(if_pc),    32'h2000);
    bus_rdy     = 1'b1;
    bus_rd_data = 32'h55;
    #1;
    checkOutput("rdy_busy",  32'(busy),     32'h0);
    tick(1);
    checkOutput("rdy_pc",    32'(if_pc),    32'h2001);
    checkOutput("rdy_inst",  if_inst,       32'h55);

    // Asynchronous reset in the middle of a bus access.
    bus_rdy = 1'b0;
    tick(2);
    checkOutput("mr_as1",    32'(bus_as),   32'h1);
    rst = 1'b1;
    #1;
    checkOutput("mr_req",    32'(bus_req),  32'h0);
    checkOutput("mr_as",     32'(bus_as),   32'h0);
    checkOutput("mr_pc",     32'(if_pc),    32'h0);
    checkOutput("mr_en",     32'(if_en),    32'h0);
    tick(1);
    rst         = 1'b0;
    bus_rdy     = 1'b1;
    bus_rd_data = 32'h2;

    // Fetch from the scratch-pad region.
    flush       = 1'b1;
    new_pc      = 30'h08000000;
    spm_rd_data = 32'h1;
    tick(1);
    checkOutput("sp_load",   32'(if_pc),    32'h08000000);
    flush = 1'b0;
    #1;
`ifdef IF_SPM_FETCH_EN
    checkOutput("sp_as",     32'(spm_as),   32'h1);
    checkOutput("sp_busy",   32'(busy),     32'h0);
    checkOutput("sp_addr",   32'(spm_addr), 32'h08000000);
    tick(1);
    checkOutput("sp_pc1",    32'(if_pc),    32'h08000001);
    checkOutput("sp_inst",   if_inst,       32'h1);
    checkOutput("sp_en",     32'(if_en),    32'h1);
    checkOutput("sp_req",    32'(bus_req),  32'h0);
    tick(1);
    checkOutput("sp_pc2",    32'(if_pc),    32'h08000002);
    stall = 1'b1;
    #1;
    checkOutput("sp_stl_as", 32'(spm_as),   32'h0);
    tick(1);
    checkOutput("sp_stl_pc", 32'(if_pc),    32'h08000002);
    stall = 1'b0;
`else
    checkOutput("sp_as",     32'(spm_as),   32'h0);
    checkOutput("sp_busy",   32'(busy),     32'h1);
    tick(3);
    checkOutput("sp_pc1",    32'(if_pc),    32'h08000001);
    checkOutput("sp_inst",   if_inst,       32'h2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
